// File: rtl/lab1_imul_req_packer.sv
// Purpose: packs an a-then-b operand word stream into {a,b} multiply requests and queues them.
// Latency: a request appears on ostream the cycle after its b word is accepted (no bypass).
// Backpressure: a is always accepted; b stalls while the queue is full; ostream_msg is held while stalled.
//
// Ports:
//   clk, reset                 - clock; synchronous active-high reset
//   istream_val/rdy/msg        - p_nbits-wide operand words, a first then b
//   ostream_val/rdy/msg        - 2*p_nbits-wide packed request {a,b} (a in the upper half)
//   num_reqs                   - count of ostream transfers (only with LAB1_IMUL_REQ_PACKER_STATS_EN)
//
// Optional feature macro: LAB1_IMUL_REQ_PACKER_STATS_EN adds the num_reqs counter port.

module lab1_imul_req_packer #(
    parameter int p_num_entries = 2,
    parameter int p_nbits       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    input  logic [p_nbits-1:0]     istream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [2*p_nbits-1:0]   ostream_msg
`ifdef LAB1_IMUL_REQ_PACKER_STATS_EN
    ,
    output logic [31:0]            num_reqs
`endif
);

    // A one-entry queue still needs a one-bit pointer; it simply never leaves 0.
    localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int CW = $clog2(p_num_entries + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(p_num_entries - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(p_num_entries);

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t                 state;
    logic [p_nbits-1:0]     a_reg;
    logic [2*p_nbits-1:0]   entry [p_num_entries];
    logic [PW-1:0]          enq_ptr;
    logic [PW-1:0]          deq_ptr;
    logic [CW-1:0]          count;

    logic in_xfer;
    logic out_xfer;
    logic enq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // istream_rdy looks only at registered count, so a dequeue in this cycle
    // cannot make room for b in the same cycle; this keeps ostream_rdy off the
    // istream_rdy path.
    always_comb begin
        istream_rdy = !reset && ((state == WAIT_A) || (count < FULL_CNT));
        ostream_val = !reset && (count != '0);
        ostream_msg = entry[deq_ptr];
    end

    assign in_xfer  = istream_val && istream_rdy;
    assign out_xfer = ostream_val && ostream_rdy;
    assign enq      = in_xfer && (state == WAIT_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT_A;
            a_reg   <= '0;
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            if (in_xfer) begin
                if (state == WAIT_A) begin
                    a_reg <= istream_msg;
                    state <= WAIT_B;
                end else begin
                    state <= WAIT_A;
                end
            end

            if (enq) begin
                enq_ptr <= ptr_inc(enq_ptr);
            end
            if (out_xfer) begin
                deq_ptr <= ptr_inc(deq_ptr);
            end

            case ({enq, out_xfer})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry[enq_ptr] <= {a_reg, istream_msg};
        end
    end

`ifdef LAB1_IMUL_REQ_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            num_reqs <= '0;
        end else if (out_xfer) begin
            num_reqs <= num_reqs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lab1_imul_req_packer.sv
module tb_lab1_imul_req_packer;

    logic        clk;
    logic        reset;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [63:0] ostream_msg;
`ifdef LAB1_IMUL_REQ_PACKER_STATS_EN
    logic [31:0] num_reqs;
`endif

    lab1_imul_req_packer #(
        .p_num_entries(2),
        .p_nbits(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .istream_val(istream_val),
        .istream_rdy(istream_rdy),
        .istream_msg(istream_msg),
        .ostream_val(ostream_val),
        .ostream_rdy(ostream_rdy),
        .ostream_msg(ostream_msg)
`ifdef LAB1_IMUL_REQ_PACKER_STATS_EN
        ,
        .num_reqs(num_reqs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] im;
        logic        ordy;
        logic        e_irdy;
        logic        e_oval;
        logic [63:0] e_omsg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic iv, input logic [31:0] im, input logic ordy,
                       input logic e_irdy, input logic e_oval, input logic [63:0] e_omsg);
        vec_t v;
        v.rst = rst; v.iv = iv; v.im = im; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_oval = e_oval; v.e_omsg = e_omsg;
        vecs.push_back(v);
    endtask

    // Random-phase state
    logic [31:0] words[200];
    logic [63:0] exp_req[100];

    initial begin
        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b0;

        // Each row is one cycle: inputs driven, outputs expected in that cycle.
        // Reset state
        add(1, 0, 32'h0, 0, 0, 0, 64'h0);
        add(1, 0, 32'h0, 0, 0, 0, 64'h0);
        // Basic pair, sink ready
        add(0, 1, 32'h3, 1, 1, 0, 64'h0);
        add(0, 1, 32'h4, 1, 1, 0, 64'h0);
        add(0, 0, 32'h0, 1, 1, 1, 64'h00000003_00000004);
        add(0, 0, 32'h0, 1, 1, 0, 64'h0);
        // Back-to-back pairs
        add(0, 1, 32'h2,        1, 1, 0, 64'h0);
        add(0, 1, 32'h3,        1, 1, 0, 64'h0);
        add(0, 1, 32'hFFFFFFFF, 1, 1, 1, 64'h00000002_00000003);
        add(0, 1, 32'h1,        1, 1, 0, 64'h0);
        add(0, 1, 32'h80000000, 1, 1, 1, 64'hFFFFFFFF_00000001);
        add(0, 1, 32'h2,        1, 1, 0, 64'h0);
        add(0, 0, 32'h0,        1, 1, 1, 64'h80000000_00000002);
        add(0, 0, 32'h0,        1, 1, 0, 64'h0);
        // Full queue with stalled sink
        add(0, 1, 32'h1, 0, 1, 0, 64'h0);
        add(0, 1, 32'h2, 0, 1, 0, 64'h0);
        add(0, 1, 32'h3, 0, 1, 1, 64'h00000001_00000002);
        add(0, 1, 32'h4, 0, 1, 1, 64'h00000001_00000002);
        add(0, 1, 32'h5, 0, 1, 1, 64'h00000001_00000002);
        add(0, 1, 32'h6, 0, 0, 1, 64'h00000001_00000002);
        add(0, 1, 32'h6, 1, 0, 1, 64'h00000001_00000002);
        add(0, 1, 32'h6, 0, 1, 1, 64'h00000003_00000004);
        add(0, 0, 32'h0, 1, 1, 1, 64'h00000003_00000004);
        add(0, 0, 32'h0, 1, 1, 1, 64'h00000005_00000006);
        add(0, 0, 32'h0, 0, 1, 0, 64'h0);
        // Simultaneous enqueue and dequeue with count=1
        add(0, 1, 32'h11, 0, 1, 0, 64'h0);
        add(0, 1, 32'h22, 0, 1, 0, 64'h0);
        add(0, 1, 32'h33, 0, 1, 1, 64'h00000011_00000022);
        add(0, 1, 32'h44, 1, 1, 1, 64'h00000011_00000022);
        add(0, 0, 32'h0,  0, 1, 1, 64'h00000033_00000044);
        add(0, 0, 32'h0,  1, 1, 1, 64'h00000033_00000044);
        add(0, 0, 32'h0,  1, 1, 0, 64'h0);
        // Reset mid-pair
        add(0, 1, 32'h7, 1, 1, 0, 64'h0);
        add(1, 0, 32'h0, 1, 0, 0, 64'h0);
        add(0, 1, 32'h8, 1, 1, 0, 64'h0);
        add(0, 1, 32'h9, 1, 1, 0, 64'h0);
        add(0, 0, 32'h0, 1, 1, 1, 64'h00000008_00000009);
        add(0, 0, 32'h0, 1, 1, 0, 64'h0);
        // Reset discards a queued entry
        add(0, 1, 32'hA, 0, 1, 0, 64'h0);
        add(0, 1, 32'hB, 0, 1, 0, 64'h0);
        add(1, 0, 32'h0, 0, 0, 0, 64'h0);
        add(0, 0, 32'h0, 1, 1, 0, 64'h0);
        add(0, 0, 32'h0, 1, 1, 0, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            istream_val = vecs[i].iv;
            istream_msg = vecs[i].im;
            ostream_rdy = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_istream_rdy", i), {63'b0, istream_rdy}, {63'b0, vecs[i].e_irdy});
            chk($sformatf("vec%0d_ostream_val", i), {63'b0, ostream_val}, {63'b0, vecs[i].e_oval});
            if (vecs[i].e_oval) begin
                chk($sformatf("vec%0d_ostream_msg", i), ostream_msg, vecs[i].e_omsg);
            end
        end

        // Random source/sink phase against an ordered pair-packing model.
        for (int i = 0; i < 200; i++) words[i] = $urandom;
        for (int i = 0; i < 100; i++) exp_req[i] = {words[2*i], words[2*i+1]};

        @(negedge clk);
        reset       = 1'b1;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        begin
            int          wi;
            int          out_idx;
            int          src_wait;
            int          snk_wait;
            int          cyc;
            logic        prev_stall;
            logic [63:0] prev_msg;
            logic        in_x;
            logic        out_x;

            wi = 0; out_idx = 0; cyc = 0;
            src_wait = $urandom_range(0, 3);
            snk_wait = $urandom_range(0, 3);
            prev_stall = 1'b0;
            prev_msg = '0;

            while (out_idx < 100 && cyc < 5000) begin
                if (cyc != 0) @(negedge clk);
                cyc++;
                istream_val = (wi < 200) && (src_wait == 0);
                istream_msg = (wi < 200) ? words[wi] : 32'h0;
                ostream_rdy = (snk_wait == 0);
                #1;
                in_x  = istream_val && istream_rdy;
                out_x = ostream_val && ostream_rdy;

                if (prev_stall) begin
                    chk("hold_val", {63'b0, ostream_val}, 64'd1);
                    chk("hold_msg", ostream_msg, prev_msg);
                end
                if (ostream_val) begin
                    // No bypass: only pairs completed in earlier cycles may be offered.
                    chk("val_has_pair", {63'b0, (out_idx < wi / 2)}, 64'd1);
                end
                if (out_x) begin
                    if (out_idx < 100) chk($sformatf("rand_req%0d", out_idx), ostream_msg, exp_req[out_idx]);
                    out_idx++;
                end
                prev_stall = ostream_val && !ostream_rdy;
                prev_msg   = ostream_msg;

                if (in_x) begin
                    wi++;
                    src_wait = $urandom_range(0, 3);
                end else if (src_wait > 0) begin
                    src_wait--;
                end
                if (out_x) begin
                    snk_wait = $urandom_range(0, 3);
                end else if (snk_wait > 0) begin
                    snk_wait--;
                end
            end
            chk("random_all_received", 64'(out_idx), 64'd100);
            chk("random_all_sent", 64'(wi), 64'd200);
        end

        @(negedge clk);
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        #1;
        chk("random_drained_val", {63'b0, ostream_val}, 64'd0);
`ifdef LAB1_IMUL_REQ_PACKER_STATS_EN
        chk("num_reqs", {32'b0, num_reqs}, 64'd100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab1_imul_req_packer.md
Name: lab1_imul_req_packer

Overview:
Upstream stage of the iterative integer multiplier. Accepts a narrow 32-bit val/rdy stream of operands, alternating a then b. Packs each pair into the 64-bit request {a,b}: a in bits [63:32], b in bits [31:0]. Buffers packed requests in a small circular queue so operand collection overlaps with a multi-cycle multiply in progress; its ostream connects directly to the multiplier's istream.

Parameters:
p_num_entries, 2, depth of packed-request queue; power of two, >= 1
p_nbits, 32, operand width; packed message is 2*p_nbits

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
istream_val  input  1  operand word valid
istream_rdy  output  1  packer can accept operand word
istream_msg  input  p_nbits  operand word (a first, then b)
ostream_val  output  1  packed request valid
ostream_rdy  input  1  multiplier ready for request
ostream_msg  output  2*p_nbits  packed request {a,b}

Behaviour:
- Transfer on a stream occurs in a cycle where val && rdy at posedge.
- FSM states: WAIT_A (0), WAIT_B (1); state register reset to WAIT_A.
- WAIT_A:
  - istream_rdy = 1 (not gated by queue occupancy).
  - On transfer: a_reg <= istream_msg; go to WAIT_B.
- WAIT_B:
  - istream_rdy = (count < p_num_entries). Uses registered count only; no same-cycle full-pass, so no combinational path from ostream_rdy to istream_rdy.
  - On transfer: enqueue {a_reg, istream_msg} at enq_ptr; go to WAIT_A.
- Queue:
  - Entry array, enq_ptr, deq_ptr, count (width clog2(p_num_entries+1)).
  - Pointers wrap modulo p_num_entries.
  - ostream_val = (count != 0); ostream_msg = entry[deq_ptr], driven combinationally from storage.
  - Dequeue on ostream transfer; deq_ptr advances.
- Count update:
  - enq only: +1; deq only: -1; simultaneous enq and deq: unchanged, both pointers advance.
- Latency: packed request visible on ostream the cycle after b is accepted, if the queue was empty. No bypass path.
- ostream_msg holds stable while ostream_val=1 and ostream_rdy=0.
- Full queue:
  - In WAIT_B, b is stalled (istream_rdy=0) until a dequeue has reduced count.
  - In WAIT_A, a is still accepted and held in a_reg.
- Empty queue: ostream_val=0; ostream_msg is don't-care.
- Reset:
  - While reset high: istream_rdy=0 and ostream_val=0.
  - Next state: WAIT_A, count=0, enq_ptr=deq_ptr=0, a_reg=0.
- Reset mid-operation: a half-collected pair (state WAIT_B) and all queued entries are discarded. First word after reset is treated as a.
- Storage entries are not reset; they are never observable while count=0.
- No arithmetic on data; widths preserved exactly; no sign handling.

Optional Feature:
LAB1_IMUL_REQ_PACKER_STATS_EN
- Defined:
  - Adds output port num_reqs [31:0], a counter of ostream transfers.
  - Counter reset to 0; +1 per ostream transfer; wraps 0xFFFFFFFF -> 0.
  - Line trace appends the counter value.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic pair, sink always ready: send 0x00000003 then 0x00000004 → one cycle after b accepted, ostream_val=1, ostream_msg=0x0000000300000004, for exactly 1 cycle.
- Back-to-back pairs: stream (2,3),(0xFFFFFFFF,1),(0x80000000,2) with continuous val → outputs 0x0000000200000003, 0xFFFFFFFF00000001, 0x8000000000000002 in order; istream_rdy never drops.
- Full queue, sink stalled (ostream_rdy=0), p_num_entries=2:
  - Send pairs (1,2),(3,4), then a=5 → a=5 accepted; b=6 sees istream_rdy=0.
  - Raise ostream_rdy for 1 cycle → 0x0000000100000002 dequeued; b=6 accepted the following cycle.
  - Final order: (1,2),(3,4),(5,6).
- Simultaneous enq/deq: with count=1 and ostream_rdy=1, accept b in the same cycle → count stays 1; ostream_msg advances to the new pair next cycle.
- Reset mid-pair: accept a=7, assert reset 1 cycle, then send 8,9 → output 0x0000000800000009; no entry containing 7.
- Random source/sink delays (0–3 cycles), 100 random pairs → outputs match the reference packing model in order. With LAB1_IMUL_REQ_PACKER_STATS_EN defined: num_reqs=100 at end.
